// File: rtl/resp_sb_pkg.sv
// resp_sb_pkg: FSM state encoding, error codes and a saturating increment.
package resp_sb_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_UNEXP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/resp_sb_if.sv
// resp_sb_if: expected/actual streams and result outputs of the response scoreboard.
interface resp_sb_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
  logic             clear;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             err;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] err_exp;
  logic [WIDTH-1:0] err_act;
  logic             idle;
  modport master (
    output clear, exp_valid, exp_data, act_valid, act_data, mask,
    input  exp_ready, match_cnt, miss_cnt, err, err_code, err_exp, err_act, idle
  );
  modport slave (
    input  clear, exp_valid, exp_data, act_valid, act_data, mask,
    output exp_ready, match_cnt, miss_cnt, err, err_code, err_exp, err_act, idle
  );
endinterface

// File: rtl/resp_sb_fifo.sv
// resp_sb_fifo: synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module resp_sb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end

    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/resp_scoreboard.sv
// resp_scoreboard: in-order compare of a DUT output stream against queued expected words,
// with match/miss counters, first-error capture and a WAIT-state inactivity timeout.
module resp_scoreboard
    import resp_sb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input logic    clk_i,
    input logic    rst_i,
    resp_sb_if.slave sb
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [31:0] CMAX = 32'({CNT_W{1'b1}});
    logic [1:0]       state, state_nx;
    logic [TW-1:0]    tmo_cnt;
    logic [WIDTH-1:0] head;
    logic             full, empty, push, pop, hit, mis, unexp, tmo;

    resp_sb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush(sb.clear), .push(push), .pop(pop),
        .wdata(sb.exp_data), .head(head), .full(full), .empty(empty)
    );

    assign sb.exp_ready = !full;
    assign sb.idle      = state == S_IDLE;
    assign push  = sb.exp_valid & !full & !sb.clear;
    assign pop   = sb.act_valid & !empty & !sb.clear;
    assign hit   = sb.act_valid & !empty;
    assign mis   = hit & (((sb.act_data ^ head) & sb.mask) != '0);
    assign unexp = sb.act_valid & empty;
    // Activity always wins over an expiring timer in the same cycle.
    assign tmo   = (state == S_WAIT) & !sb.act_valid & (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb
        state_nx = (state == S_FAIL || mis || unexp || tmo) ? S_FAIL : empty ? S_IDLE : S_WAIT;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            sb.match_cnt <= '0;
            sb.miss_cnt  <= '0;
            sb.err       <= 1'b0;
            sb.err_code  <= ERR_NONE;
            sb.err_exp   <= '0;
            sb.err_act   <= '0;
        end else if (sb.clear) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            sb.match_cnt <= '0;
            sb.miss_cnt  <= '0;
            sb.err       <= 1'b0;
            sb.err_code  <= ERR_NONE;
            sb.err_exp   <= '0;
            sb.err_act   <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= (state != S_WAIT || sb.act_valid || state_nx != state) ? '0 : tmo_cnt + TW'(1);
            if (hit && !mis) sb.match_cnt <= CNT_W'(sat_inc(32'(sb.match_cnt), CMAX));
            if (mis || unexp) sb.miss_cnt <= CNT_W'(sat_inc(32'(sb.miss_cnt), CMAX));
            // Only the first error is recorded; later ones still count as misses.
            if (!sb.err && (mis || unexp || tmo)) begin
                sb.err      <= 1'b1;
                sb.err_code <= mis ? ERR_MISMATCH : unexp ? ERR_UNEXP : ERR_TIMEOUT;
                sb.err_exp  <= unexp ? '0 : head;
                sb.err_act  <= tmo ? '0 : sb.act_data;
            end
        end
endmodule

// File: tb/tb_resp_scoreboard.sv
// tb_resp_scoreboard: directed vectors against two scoreboards, default timeout and TIMEOUT=8.
module tb_resp_scoreboard;
  import resp_sb_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  resp_sb_if #(.WIDTH(8), .CNT_W(16)) a ();
  resp_sb_if #(.WIDTH(8), .CNT_W(16)) b ();
  resp_scoreboard #(.WIDTH(8), .DEPTH(16), .TIMEOUT(1024), .CNT_W(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .sb(a));
  resp_scoreboard #(.WIDTH(8), .DEPTH(16), .TIMEOUT(8), .CNT_W(16)) dut_t (.clk_i(clk_i), .rst_i(rst_i), .sb(b));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    a.exp_valid = 1'b1;
    a.exp_data = d;
    tick();
    a.exp_valid = 1'b0;
  endtask
  task automatic act(input logic [7:0] d);
    a.act_valid = 1'b1;
    a.act_data = d;
    tick();
    a.act_valid = 1'b0;
  endtask
  task automatic clr();
    a.clear = 1'b1;
    tick();
    a.clear = 1'b0;
  endtask
  initial begin
    {a.clear, a.exp_valid, a.act_valid, a.exp_data, a.act_data} = '0;
    {b.clear, b.exp_valid, b.act_valid, b.exp_data, b.act_data} = '0;
    a.mask = 8'hFF;
    b.mask = 8'hFF;
    tick();
    tick();
    check("rst_match", 32'(a.match_cnt), 0);
    check("rst_miss", 32'(a.miss_cnt), 0);
    check("rst_err", 32'(a.err), 0);
    check("rst_code", 32'(a.err_code), 0);
    check("rst_ready", 32'(a.exp_ready), 1);
    check("rst_idle", 32'(a.idle), 1);
    rst_i = 1'b0;
    tick();
    // in-order matches
    push(8'h01); push(8'h02); push(8'h03);
    act(8'h01); act(8'h02); act(8'h03);
    tick(); tick();
    check("t1_match", 32'(a.match_cnt), 3);
    check("t1_miss", 32'(a.miss_cnt), 0);
    check("t1_err", 32'(a.err), 0);
    check("t1_idle", 32'(a.idle), 1);
    // mismatch then masked match
    clr();
    push(8'hA5);
    act(8'hA4);
    check("t2_miss", 32'(a.miss_cnt), 1);
    check("t2_err", 32'(a.err), 1);
    check("t2_code", 32'(a.err_code), 1);
    check("t2_exp", 32'(a.err_exp), 32'hA5);
    check("t2_act", 32'(a.err_act), 32'hA4);
    push(8'hA5);
    a.mask = 8'hFE;
    act(8'hA4);
    a.mask = 8'hFF;
    check("t2_match", 32'(a.match_cnt), 1);
    check("t2_code_held", 32'(a.err_code), 1);
    check("t2_act_held", 32'(a.err_act), 32'hA4);
    // unexpected word
    clr();
    act(8'h10);
    check("t3_miss", 32'(a.miss_cnt), 1);
    check("t3_code", 32'(a.err_code), 2);
    check("t3_act", 32'(a.err_act), 32'h10);
    check("t3_exp", 32'(a.err_exp), 0);
    tick();
    check("t3_state", 32'(dut.state), 32'(S_FAIL));
    check("t3_idle", 32'(a.idle), 0);
    // fill to full, hold the 17th offer
    clr();
    a.exp_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a.exp_data = 8'(8'h20 + i);
      tick();
    end
    a.exp_data = 8'h30;
    check("t4_full", 32'(a.exp_ready), 0);
    tick();
    check("t4_still_full", 32'(a.exp_ready), 0);
    a.act_valid = 1'b1;
    a.act_data = 8'h20;
    tick();
    a.act_valid = 1'b0;
    check("t4_ready_back", 32'(a.exp_ready), 1);
    tick();
    a.exp_valid = 1'b0;
    check("t4_refull", 32'(a.exp_ready), 0);
    for (int i = 1; i < 17; i++) act(8'(8'h20 + i));
    check("t4_match", 32'(a.match_cnt), 17);
    check("t4_miss", 32'(a.miss_cnt), 0);
    check("t4_err", 32'(a.err), 0);
    // timeout on the TIMEOUT=8 instance
    b.exp_valid = 1'b1;
    b.exp_data = 8'h55;
    tick();
    b.exp_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t5_no_err_yet", 32'(b.err), 0);
    tick();
    check("t5_err", 32'(b.err), 1);
    check("t5_code", 32'(b.err_code), 3);
    check("t5_exp", 32'(b.err_exp), 32'h55);
    check("t5_act", 32'(b.err_act), 0);
    b.clear = 1'b1;
    tick();
    b.clear = 1'b0;
    check("t5_clr_err", 32'(b.err), 0);
    check("t5_clr_code", 32'(b.err_code), 0);
    check("t5_clr_exp", 32'(b.err_exp), 0);
    check("t5_clr_ready", 32'(b.exp_ready), 1);
    check("t5_clr_idle", 32'(b.idle), 1);
    check("t5_clr_miss", 32'(b.miss_cnt), 0);
    // asynchronous reset with entries queued
    clr();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    tick();
    check("t6_busy", 32'(a.idle), 0);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_idle", 32'(a.idle), 1);
    check("t6_rst_match", 32'(a.match_cnt), 0);
    check("t6_rst_ready", 32'(a.exp_ready), 1);
    tick();
    rst_i = 1'b0;
    act(8'h77);
    check("t6_code", 32'(a.err_code), 2);
    check("t6_miss", 32'(a.miss_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
